fcvt_itof_ctrl: RTL
===================

# fcvt_itof_ctrl

Sequencing and arbitration controller for the FPU integer-to-float conversion path. It accepts conversion requests from two requesters over valid/ready handshakes and arbitrates between them round-robin. It resolves the rounding mode and extends 32-bit operands, then drives the existing `itof` converter core from a registered operand stage. It returns results through a two-stage, back-pressurable pipeline with a tag and flush. The block sits between the FPU issue logic and FPU writeback.

## Interface
Parameters:
- `expWidth`, 8: result exponent width.
- `sigWidth`, 24: result significand width, including the hidden bit.
- `intWidth`, 64: integer operand width; must be ≥ 33.
- `TAG_W`, 4: request tag width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: kill all in-flight operations.
- `frm`, in, 3: dynamic rounding mode (CSR).
- `req_valid[1:0]`, in, 2: request valid, one bit per requester.
- `req_ready[1:0]`, out, 2: request accepted, one bit per requester.
- `req_a0`, `req_a1`, in, intWidth: integer operand.
- `req_signed[1:0]`, in, 2: operand is signed.
- `req_word[1:0]`, in, 2: use only the low 32 bits of the operand.
- `req_rm0`, `req_rm1`, in, 3: rounding mode; 3'b111 selects dynamic (`frm`).
- `req_tag0`, `req_tag1`, in, TAG_W: request tag.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream can take the result.
- `out_data`, out, expWidth+sigWidth: IEEE result.
- `out_flags`, out, 5: {NV, DZ, OF, UF, NX}.
- `out_illegal`, out, 1: the resolved rounding mode was reserved.
- `out_src`, out, 1: which requester issued the result.
- `out_tag`, out, TAG_W: tag of the result.

## Operation
- **Stage S1 (operand register).** Holds the operand, signed flag, resolved rm, illegal flag, source, tag and valid `s1_v`.
- **Stage S2 (result register).** Holds `out_data`, `out_flags`, `out_illegal`, `out_src`, `out_tag` and `out_valid`.
- **Stage advance.**
  - `s2_load = s1_v && (!out_valid || out_ready)`.
  - `s1_load = !flush && (!s1_v || s2_load)`.
- **Arbiter.**
  - Round-robin over the two requesters with a 1-bit priority pointer.
  - If both are valid, grant the pointer's port. If one is valid, grant it.
  - `req_ready[i] = s1_load && grant[i]`.
  - On each handshake the pointer moves to the other port.
  - Grant may depend on `req_valid`; `req_valid` must not depend on `req_ready`.
- **Word mode.** The low 32 bits are sign-extended (signed) or zero-extended (unsigned) to intWidth before S1.
- **Rounding mode.**
  - rm = 7 is resolved to `frm` at acceptance.
  - A resolved rm of 5, 6 or 7 sets the S1 illegal flag.
- **Converter.**
  - `itof` is driven combinationally from S1, with control tied to 0, gate tied to 1, and `signedOut` taken from the S1 signed flag.
  - If illegal, S2 loads data 0, flags 0 and `out_illegal` = 1.
- **Output hold.** While `out_valid && !out_ready`, all `out_*` signals hold stable.
- **Flush.**
  - In the cycle `flush` is high, `req_ready` = 0.
  - On the next edge, `s1_v` and `out_valid` clear.
  - The arbiter pointer is unchanged.
- **Reset.**
  - Clears `s1_v` and `out_valid`.
  - Clears `out_data`, `out_flags`, `out_illegal`, `out_src` and `out_tag` to 0.
  - Sets the pointer to port 0.
  - `rst` overrides `flush`, including mid-operation.

## Timing
- **Latency.** A handshake in cycle t gives `out_valid` in cycle t+2, provided there is no back-pressure.
- **Throughput.** One conversion per cycle with `out_ready` held high. Requests alternate between ports when both are valid.
- **Full condition.** With S1 and S2 both valid and `out_ready` = 0, `req_ready` = 0.
- **Simultaneous events.** In a cycle where `out_ready` = 1, S2 drains, S1 moves to S2 and a new request enters S1, all in that cycle.
- **`req_ready` timing.** `req_ready` is combinational from `out_ready`, `flush` and the stage valids. It never depends on the requester's own data.

## Structure
- **Package `fcvt_pkg`.**
  - Rounding-mode constants: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7.
  - Flag bit indices: NV=4, DZ=3, OF=2, UF=1, NX=0.
  - A function for the reserved-rm check.
- **Sub-module `rr_arb2`.** Two-requester round-robin arbiter holding the pointer. Inputs are valids and an advance strobe; the output is a one-hot grant.
- **Converter.** The existing `itof` core is instantiated once.

## Test plan
- **Signed one.** Port 0, a=1, signed, rm=RNE, fp32 → `out_data`=0x3F800000, flags=0, returned 2 cycles after the handshake.
- **Rounding.** a=16777217 with RNE → 0x4B800000, flags=5'b00001. The same operand with rm=RUP → 0x4B800001, NX set.
- **Word mode.**
  - a=0xFFFFFFFF_FFFFFFFF, word, signed → 0xBF800000, flags 0.
  - The same operand, word, unsigned → 0x4F800000, NX=1.
- **Arbitration and back-pressure.**
  - Both ports valid continuously with tags 0..7 → grants alternate 0,1,0,1 starting from port 0.
  - Hold `out_ready`=0 for 3 cycles → `req_ready`=0 once S1/S2 are full, outputs stay stable, and no result is lost or duplicated.
- **Dynamic and reserved rm.**
  - rm=7 with frm=RTZ, a=16777217 → 0x4B800000.
  - rm=7 with frm=5 → `out_illegal`=1, data 0, flags 0.
  - rm=6 → `out_illegal`=1.
- **Flush and reset mid-operation.**
  - `flush` with two ops in flight → `out_valid`=0 next cycle and `req_ready`=0 during the flush cycle; the next request returns normally.
  - `rst` mid-stream → all outputs are 0 and grants start from port 0.

Source files
------------

// File: rtl/fcvt_pkg.sv
// Shared constants and helpers for the integer-to-float conversion path.
package fcvt_pkg;

    typedef logic [2:0] rm_t;

    // Rounding-mode encodings as seen on the request ports and frm.
    localparam rm_t RNE = 3'd0;
    localparam rm_t RTZ = 3'd1;
    localparam rm_t RDN = 3'd2;
    localparam rm_t RUP = 3'd3;
    localparam rm_t RMM = 3'd4;
    localparam rm_t DYN = 3'd7;

    // Bit positions inside the 5-bit exception flag vector {NV, DZ, OF, UF, NX}.
    localparam int unsigned NV = 4;
    localparam int unsigned DZ = 3;
    localparam int unsigned OF = 2;
    localparam int unsigned UF = 1;
    localparam int unsigned NX = 0;

    // A resolved rounding mode of 5, 6 or 7 has no defined meaning.
    function automatic logic isReservedRm(input rm_t rm);
        return rm >= 3'd5;
    endfunction

endpackage

// File: rtl/itof.sv
// Integer-to-float converter core: signed/unsigned integer in, IEEE binary out.
module itof
    import fcvt_pkg::*;
#(
    parameter int unsigned intWidth = 64,
    parameter int unsigned expWidth = 8,
    parameter int unsigned sigWidth = 24
) (
    input  logic                         control,
    input  logic                         gate,
    input  logic                         signedOut,
    input  logic [intWidth-1:0]          intIn,
    input  logic [2:0]                   roundingMode,
    output logic [expWidth+sigWidth-1:0] out,
    output logic [4:0]                   exceptionFlags
);

    localparam int unsigned WideW = intWidth + sigWidth + 1;
    localparam int unsigned PosW  = $clog2(intWidth);
    localparam int          Bias  = (1 << (expWidth - 1)) - 1;
    localparam int          ExpMax = (1 << expWidth) - 1;

    // Tininess control has no effect: an integer never produces a subnormal.
    logic unusedControl;
    assign unusedControl = control;

    logic                  neg;
    logic [intWidth-1:0]   mag;
    logic                  nonZero;
    logic [PosW-1:0]       msbPos;
    logic [PosW-1:0]       lzc;
    logic [WideW-1:0]      wide;
    logic [sigWidth-1:0]   sig;
    logic                  guardBit;
    logic                  stickyBit;
    logic                  inexact;
    logic                  roundUp;
    logic [sigWidth:0]     sigRnd;
    logic                  carry;
    logic [sigWidth-2:0]   frac;
    logic [31:0]           expBiased;
    logic                  overflow;
    logic                  toInf;

    // Sign/magnitude split and leading-one search.
    always_comb begin
        neg     = signedOut && intIn[intWidth-1];
        mag     = neg ? (~intIn + intWidth'(1)) : intIn;
        nonZero = |mag;
        msbPos  = '0;
        for (int i = 0; i < int'(intWidth); i++) begin
            if (mag[i]) msbPos = PosW'(i);
        end
    end

    // Normalise so the leading one sits at the top, then pick significand, guard and sticky.
    always_comb begin
        lzc       = PosW'(intWidth - 1) - msbPos;
        wide      = {mag, {(sigWidth + 1){1'b0}}} << lzc;
        sig       = wide[WideW-1 -: sigWidth];
        guardBit  = wide[WideW-1-sigWidth];
        stickyBit = |wide[WideW-2-sigWidth:0];
        inexact   = guardBit || stickyBit;
    end

    // Round-increment decision per rounding mode.
    always_comb begin
        case (roundingMode)
            RNE:     roundUp = guardBit && (stickyBit || sig[0]);
            RTZ:     roundUp = 1'b0;
            RDN:     roundUp = neg && inexact;
            RUP:     roundUp = !neg && inexact;
            RMM:     roundUp = guardBit;
            default: roundUp = 1'b0;
        endcase
    end

    // Apply rounding, renormalise on carry-out and pack the result.
    always_comb begin
        sigRnd    = {1'b0, sig} + {{sigWidth{1'b0}}, roundUp};
        carry     = sigRnd[sigWidth];
        frac      = carry ? '0 : sigRnd[sigWidth-2:0];
        expBiased = 32'(Bias) + 32'(msbPos) + 32'(carry);
        // Only reachable for narrow exponents relative to intWidth.
        overflow  = expBiased >= 32'(ExpMax);
        toInf     = (roundingMode == RNE) || (roundingMode == RMM) ||
                    ((roundingMode == RUP) && !neg) || ((roundingMode == RDN) && neg);
        out            = '0;
        exceptionFlags = '0;
        if (gate && nonZero) begin
            if (overflow) begin
                out = toInf ? {neg, {expWidth{1'b1}}, {(sigWidth - 1){1'b0}}}
                            : {neg, {(expWidth - 1){1'b1}}, 1'b0, {(sigWidth - 1){1'b1}}};
            end else begin
                out = {neg, expBiased[expWidth-1:0], frac};
            end
            exceptionFlags[OF] = overflow;
            exceptionFlags[NX] = inexact || overflow;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    // Contested cycles go to the pointer's port; otherwise grant whoever is valid.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    end

    // After each handshake, point at the port that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/fcvt_itof_ctrl.sv
// Arbitrates two itof requesters into a two-stage, back-pressurable conversion pipe.
module fcvt_itof_ctrl
    import fcvt_pkg::*;
#(
    parameter int unsigned expWidth = 8,
    parameter int unsigned sigWidth = 24,
    parameter int unsigned intWidth = 64,  // must be at least 33
    parameter int unsigned TAG_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [2:0]                   frm,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [intWidth-1:0]          req_a0,
    input  logic [intWidth-1:0]          req_a1,
    input  logic [1:0]                   req_signed,
    input  logic [1:0]                   req_word,
    input  logic [2:0]                   req_rm0,
    input  logic [2:0]                   req_rm1,
    input  logic [TAG_W-1:0]             req_tag0,
    input  logic [TAG_W-1:0]             req_tag1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [expWidth+sigWidth-1:0] out_data,
    output logic [4:0]                   out_flags,
    output logic                         out_illegal,
    output logic                         out_src,
    output logic [TAG_W-1:0]             out_tag
);

    localparam int unsigned DataW = expWidth + sigWidth;

    logic                s1V;
    logic [intWidth-1:0] s1A;
    logic                s1Signed;
    rm_t                 s1Rm;
    logic                s1Illegal;
    logic                s1Src;
    logic [TAG_W-1:0]    s1Tag;

    logic                s1Load;
    logic                s2Load;
    logic [1:0]          grant;
    logic                accept;
    logic                sel;
    logic [intWidth-1:0] selA;
    logic [intWidth-1:0] extA;
    logic                selWord;
    logic                selSigned;
    rm_t                 selRm;
    rm_t                 resRm;
    logic [TAG_W-1:0]    selTag;
    logic [DataW-1:0]    cvtData;
    logic [4:0]          cvtFlags;

    // Stage advance: S2 takes S1 when free or draining; S1 refills unless flushing.
    always_comb begin
        s2Load = s1V && (!out_valid || out_ready);
        s1Load = !flush && (!s1V || s2Load);
    end

    assign req_ready = {2{s1Load}} & grant;
    assign accept    = |req_ready;
    assign sel       = grant[1];

    rr_arb2 uArb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Mux the granted request, extend word operands and resolve the dynamic rounding mode.
    always_comb begin
        selA      = sel ? req_a1 : req_a0;
        selWord   = req_word[sel];
        selSigned = req_signed[sel];
        selRm     = sel ? req_rm1 : req_rm0;
        selTag    = sel ? req_tag1 : req_tag0;
        extA      = selA;
        if (selWord) extA = {{(intWidth - 32){selSigned & selA[31]}}, selA[31:0]};
        resRm     = (selRm == DYN) ? frm : selRm;
    end

    // S1 occupancy: cleared by reset or flush, otherwise follows the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1V <= 1'b0;
        end else if (flush) begin
            s1V <= 1'b0;
        end else if (s1Load) begin
            s1V <= accept;
        end
    end

    // S1 payload captured on each accepted request.
    always_ff @(posedge clk) begin
        if (s1Load && accept) begin
            s1A       <= extA;
            s1Signed  <= selSigned;
            s1Rm      <= resRm;
            s1Illegal <= isReservedRm(resRm);
            s1Src     <= sel;
            s1Tag     <= selTag;
        end
    end

    itof #(
        .intWidth (intWidth),
        .expWidth (expWidth),
        .sigWidth (sigWidth)
    ) uItof (
        .control        (1'b0),
        .gate           (1'b1),
        .signedOut      (s1Signed),
        .intIn          (s1A),
        .roundingMode   (s1Rm),
        .out            (cvtData),
        .exceptionFlags (cvtFlags)
    );

    // S2 result register: holds while stalled, squashes reserved-rm results to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
            out_src     <= 1'b0;
            out_tag     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2Load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2Load && !flush) begin
                out_data    <= s1Illegal ? '0 : cvtData;
                out_flags   <= s1Illegal ? '0 : cvtFlags;
                out_illegal <= s1Illegal;
                out_src     <= s1Src;
                out_tag     <= s1Tag;
            end
        end
    end

endmodule
